// File: rtl/msg_intf_pkg.sv
// Shared types and constants for the SAP message router.
// States, completion error codes and message-type encodings.
package msg_intf_pkg;

    localparam logic [7:0] SAP_MSG_TYPE_EXECUTE_REQUEST  = 8'h10;
    localparam logic [7:0] SAP_MSG_TYPE_EXECUTE_COMPLETE = 8'h11;
    localparam logic [6:0] NIF_ERRCODE_UNSUPPORTED_CMD   = 7'h01;
    localparam int         FLIT_BYTES                    = 16;

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_LOAD     = 6'b000010,
        S_DRAIN    = 6'b000100,
        S_DISPATCH = 6'b001000,
        S_COMPLETE = 6'b010000,
        S_WAIT_CPL = 6'b100000
    } state_t;

    typedef enum logic [6:0] {
        ERR_NONE            = 7'd0,
        ERR_UNSUPPORTED_CMD = NIF_ERRCODE_UNSUPPORTED_CMD,
        ERR_BAD_LENGTH      = 7'd2,
        ERR_BAD_CHANNEL     = 7'd3,
        ERR_TIMEOUT         = 7'd4
    } err_t;

    function automatic logic [6:0] nflits_of(input logic [9:0] len);
        logic [10:0] n;
        n = (11'(len) + 11'(FLIT_BYTES - 1)) / 11'(FLIT_BYTES);
        return n[6:0];
    endfunction

endpackage

// File: rtl/msg_flit_assembler.sv
// Flit buffer for the message router: counts every consumed flit and
// stores it into its slot while loading; clear zeroes buffer and count.
module msg_flit_assembler
    import msg_intf_pkg::*;
#(
    parameter int C_FLIT_WIDTH   = 128,
    parameter int C_MAX_FLITS    = 4,
    parameter int C_PACKET_WIDTH = C_MAX_FLITS * C_FLIT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      xfer,
    input  logic                      store,
    input  logic [6:0]                nflits,
    input  logic [C_FLIT_WIDTH-1:0]   data,
    output logic [C_PACKET_WIDTH-1:0] pkt,
    output logic [6:0]                cnt,
    output logic                      last
);

    assign last = xfer && (cnt == nflits - 7'd1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pkt <= '0;
            cnt <= '0;
        end else if (xfer) begin
            cnt <= cnt + 7'd1;
            if (store) begin
                for (int k = 0; k < C_MAX_FLITS; k++) begin
                    if (cnt == 7'(k))
                        pkt[k*C_FLIT_WIDTH +: C_FLIT_WIDTH] <= data;
                end
            end
        end
    end

endmodule

// File: rtl/msg_intf_router.sv
// SAP execute-request router: assembles flits into a packet, routes it to
// one engine channel and always returns a completion. Watchdog: MSG_INTF_ROUTER_TIMEOUT_EN.
module msg_intf_router
    import msg_intf_pkg::*;
#(
    parameter int C_FLIT_WIDTH   = 128,
    parameter int C_MAX_FLITS    = 4,
    parameter int C_NUM_CHANNELS = 4,
    parameter int C_PACKET_WIDTH = C_MAX_FLITS * C_FLIT_WIDTH,
    parameter int C_TIMEOUT_CYC  = 1024,
    localparam int FCW = $clog2(C_MAX_FLITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                cmd_type,
    input  logic [9:0]                cmd_length,
    input  logic [15:0]               cmd_initiator,
    input  logic [9:0]                cmd_id,
    input  logic [C_FLIT_WIDTH-1:0]   cmd_data,
    input  logic                      cmd_data_valid,
    output logic                      cmd_advance,
    output logic [C_NUM_CHANNELS-1:0] out_valid,
    input  logic [C_NUM_CHANNELS-1:0] out_accept,
    output logic [C_PACKET_WIDTH-1:0] out_data,
    output logic [FCW-1:0]            out_flits,
    output logic [7:0]                cpl_type,
    output logic [9:0]                cpl_length,
    output logic [15:0]               cpl_target,
    output logic [9:0]                cpl_id,
    output logic [6:0]                cpl_error,
    output logic                      cpl_valid,
    output logic [127:0]              cpl_data,
    output logic                      cpl_data_valid,
    input  logic                      cpl_data_ready,
    input  logic                      cpl_complete
);

    state_t      state_q, state_d;
    err_t        err_q, err_d;
    logic [15:0] init_q;
    logic [9:0]  id_q;
    logic [6:0]  nflits_q, nflits_in, cnt;
    logic [7:0]  ch_q, ch_now;
    logic        xfer, last, clr, acc, timeout, hdr_on;

    assign nflits_in   = nflits_of(cmd_length);
    assign cmd_advance = cmd_data_valid
                       & ((state_q == S_LOAD) | (state_q == S_DRAIN));
    assign xfer        = cmd_advance;
    assign ch_now      = (cnt == 7'd0) ? cmd_data[7:0] : ch_q;
    assign acc         = |(out_valid & out_accept);
    assign clr         = (state_q == S_IDLE) | timeout;

    msg_flit_assembler #(
        .C_FLIT_WIDTH  (C_FLIT_WIDTH),
        .C_MAX_FLITS   (C_MAX_FLITS),
        .C_PACKET_WIDTH(C_PACKET_WIDTH)
    ) u_asm (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .xfer  (xfer),
        .store (state_q == S_LOAD),
        .nflits(nflits_q),
        .data  (cmd_data),
        .pkt   (out_data),
        .cnt   (cnt),
        .last  (last)
    );

`ifdef MSG_INTF_ROUTER_TIMEOUT_EN
    localparam int WDW = $clog2(C_TIMEOUT_CYC + 1);
    logic [WDW-1:0] wd_q;
    logic           wd_active, progress;

    assign wd_active = (state_q == S_LOAD) | (state_q == S_DRAIN)
                     | (state_q == S_DISPATCH);
    assign progress  = xfer | acc;
    assign timeout   = wd_active & ~progress
                     & (wd_q == WDW'(C_TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !wd_active || progress || state_d != state_q)
            wd_q <= '0;
        else
            wd_q <= wd_q + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_data_valid) begin
                    if (cmd_type != SAP_MSG_TYPE_EXECUTE_REQUEST)
                        err_d = ERR_UNSUPPORTED_CMD;
                    else if (nflits_in == 7'd0
                             || nflits_in > 7'(C_MAX_FLITS))
                        err_d = ERR_BAD_LENGTH;
                    else
                        err_d = ERR_NONE;
                    // nothing to drain for a zero length: skip straight on
                    if (err_d == ERR_NONE)
                        state_d = S_LOAD;
                    else if (nflits_in == 7'd0)
                        state_d = S_COMPLETE;
                    else
                        state_d = S_DRAIN;
                end
            end
            S_LOAD: begin
                if (last) begin
                    if ({1'b0, ch_now} >= 9'(C_NUM_CHANNELS)) begin
                        err_d   = ERR_BAD_CHANNEL;
                        state_d = S_COMPLETE;
                    end else begin
                        state_d = S_DISPATCH;
                    end
                end
            end
            S_DRAIN:    if (last) state_d = S_COMPLETE;
            S_DISPATCH: if (acc) state_d = S_COMPLETE;
            S_COMPLETE: if (cpl_data_ready) state_d = S_WAIT_CPL;
            S_WAIT_CPL: if (cpl_complete) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (timeout) begin
            state_d = S_COMPLETE;
            err_d   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            err_q    <= ERR_NONE;
            init_q   <= '0;
            id_q     <= '0;
            nflits_q <= '0;
            ch_q     <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == S_IDLE && cmd_data_valid) begin
                init_q   <= cmd_initiator;
                id_q     <= cmd_id;
                nflits_q <= nflits_in;
            end
            if (state_q == S_IDLE)
                ch_q <= '0;
            else if (xfer && cnt == 7'd0)
                ch_q <= cmd_data[7:0];
        end
    end

    always_comb begin
        for (int i = 0; i < C_NUM_CHANNELS; i++)
            out_valid[i] = (state_q == S_DISPATCH) && (ch_q == 8'(i));
    end

    assign out_flits = (state_q == S_DISPATCH) ? FCW'(nflits_q) : '0;

    assign hdr_on         = (state_q == S_COMPLETE) | (state_q == S_WAIT_CPL);
    assign cpl_valid      = (state_q == S_COMPLETE);
    assign cpl_data_valid = (state_q == S_COMPLETE);
    assign cpl_type       = hdr_on ? SAP_MSG_TYPE_EXECUTE_COMPLETE : 8'h0;
    assign cpl_length     = hdr_on ? 10'd16 : 10'd0;
    assign cpl_target     = hdr_on ? init_q : 16'h0;
    assign cpl_id         = hdr_on ? id_q : 10'h0;
    assign cpl_error      = hdr_on ? err_q : 7'h0;
    assign cpl_data       = cpl_valid ? {112'h0, ch_q, 8'(nflits_q)} : 128'h0;

endmodule
